// File: rtl/updown_counter_pkg.sv
// Shared encodings for the up/down counter family: direction and edge mode.
package updown_counter_pkg;

    // Meaning of the dir input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Values accepted by the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/updown_prescaler.sv
// Enable prescaler: produces one tick every PRESCALE enabled cycles.
// The phase holds while en is low and returns to zero on rst or clr.
module updown_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // With no division the tick is simply the enable.
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, clr};
            assign tick = en;
        end else begin : g_divide
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase;

            assign tick = en && (phase == LAST);

            // Advance the phase on each enabled cycle, restarting after a tick.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    phase <= '0;
                end else if (en) begin
                    if (tick) begin
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable step inside a [MIN_VAL, MAX_VAL] window.
// Supports clear, clamped parallel load, prescaled enable, and wrap or
// saturate behaviour with a registered terminal-count pulse.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int           W         = 8,
    parameter logic [W-1:0] MIN_VAL   = '0,
    parameter logic [W-1:0] MAX_VAL   = '1,
    parameter logic [W-1:0] START_VAL = MIN_VAL,
    parameter int           SATURATE  = MODE_WRAP,
    parameter int           PRESCALE  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    input  logic [W-1:0] step,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         at_max,
    output logic         at_min
);

    // Window bounds widened by one bit so no intermediate value overflows.
    localparam logic [W:0] MIN_X   = {1'b0, MIN_VAL};
    localparam logic [W:0] MAX_X   = {1'b0, MAX_VAL};
    localparam logic [W:0] RANGE_X = MAX_X - MIN_X;

    logic         tick;
    logic [W-1:0] load_clamped;
    logic [W-1:0] tick_cnt;
    logic         tick_tc;

    logic [W:0] cnt_x;
    logic [W:0] step_x;
    logic [W:0] head;
    logic [W:0] room;
    logic [W:0] excess;
    logic [W:0] deficit;
    logic [W:0] wrap_val;

    // A clear or a load restarts the prescaler period.
    updown_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr | load),
        .tick(tick)
    );

    // Pull an out-of-window load value onto the nearest bound.
    always_comb begin
        load_clamped = load_val;
        if (load_val < MIN_VAL) begin
            load_clamped = MIN_VAL;
        end else if (load_val > MAX_VAL) begin
            load_clamped = MAX_VAL;
        end
    end

    // Work out the count and boundary flag a tick would produce right now.
    // head/room are the distances to the upper/lower bound; excess/deficit
    // are how far past that bound the step reaches, minus one.
    always_comb begin
        cnt_x    = {1'b0, cnt};
        step_x   = {1'b0, step};
        head     = MAX_X - cnt_x;
        room     = cnt_x - MIN_X;
        excess   = step_x - head - 1'b1;
        deficit  = step_x - room - 1'b1;
        wrap_val = '0;
        tick_cnt = cnt;
        tick_tc  = 1'b0;
        if (dir == DIR_UP) begin
            if (step_x > head) begin
                tick_tc = 1'b1;
                if (SATURATE == MODE_SAT || excess > RANGE_X) begin
                    tick_cnt = MAX_VAL;
                end else begin
                    wrap_val = MIN_X + excess;
                    tick_cnt = wrap_val[W-1:0];
                end
            end else begin
                wrap_val = cnt_x + step_x;
                tick_cnt = wrap_val[W-1:0];
            end
        end else begin
            if (step_x > room) begin
                tick_tc = 1'b1;
                if (SATURATE == MODE_SAT || deficit > RANGE_X) begin
                    tick_cnt = MIN_VAL;
                end else begin
                    wrap_val = MAX_X - deficit;
                    tick_cnt = wrap_val[W-1:0];
                end
            end else begin
                wrap_val = cnt_x - step_x;
                tick_cnt = wrap_val[W-1:0];
            end
        end
    end

    // Count register with fixed priority rst > clr > load > tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= START_VAL;
            tc  <= 1'b0;
        end else if (clr) begin
            cnt <= START_VAL;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= load_clamped;
            tc  <= 1'b0;
        end else if (tick) begin
            cnt <= tick_cnt;
            tc  <= tick_tc;
        end else begin
            tc  <= 1'b0;
        end
    end

    assign at_max = (cnt == MAX_VAL);
    assign at_min = (cnt == MIN_VAL);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter. Four instances with different
// parameters share one stimulus stream; each step checks the instance
// whose configuration that step exercises.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       dir;
    logic [7:0] step;

    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       at_max_a, at_max_b, at_max_c, at_max_d;
    logic       at_min_a, at_min_b, at_min_c, at_min_d;

    int checks = 0;
    int errors = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Full window, START_VAL = 5, wrap, no prescale.
    updown_counter #(.W(8), .START_VAL(8'd5)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .cnt(cnt_a), .tc(tc_a), .at_max(at_max_a), .at_min(at_min_a)
    );

    // Window [10, 20], wrap.
    updown_counter #(.W(8), .MIN_VAL(8'd10), .MAX_VAL(8'd20)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .cnt(cnt_b), .tc(tc_b), .at_max(at_max_b), .at_min(at_min_b)
    );

    // Full window, saturating.
    updown_counter #(.W(8), .SATURATE(1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .cnt(cnt_c), .tc(tc_c), .at_max(at_max_c), .at_min(at_min_c)
    );

    // Full window, tick every third enabled cycle.
    updown_counter #(.W(8), .PRESCALE(3)) dut_d (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .cnt(cnt_d), .tc(tc_d), .at_max(at_max_d), .at_min(at_min_d)
    );

    // Step must fit the narrowest window in use ([10,20] allows up to 11).
    always @(negedge clk) begin
        if (en) begin
            assert (step <= 8'd11) else begin
                errors++;
                $error("[TB] FAIL step_legal observed=%0d expected<=11", step);
            end
        end
    end

    // Drive one cycle of inputs, then advance to 1 time unit past the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic l,
                                 input logic [7:0] lv, input logic e,
                                 input logic d, input logic [7:0] s);
        rst      = r;
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        dir      = d;
        step     = s;
        @(posedge clk);
        #1;
    endtask

    // One comparison against a hand-computed value.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b0; dir = 1'b1; step = '0;

        // Reset held for two cycles.
        applyStimulus(1, 0, 0, 8'd0, 0, 1, 8'd0);
        applyStimulus(1, 0, 0, 8'd0, 0, 1, 8'd0);
        checkOutput("rst_cnt_a", cnt_a, 8'd5);
        checkOutput("rst_tc_a", {7'd0, tc_a}, 8'd0);
        checkOutput("rst_cnt_b", cnt_b, 8'd10);
        checkOutput("rst_at_min_b", {7'd0, at_min_b}, 8'd1);
        checkOutput("rst_cnt_d", cnt_d, 8'd0);

        // Three up ticks of 1, then clear.
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("up3_cnt_a", cnt_a, 8'd8);
        checkOutput("up3_cnt_d", cnt_d, 8'd1);
        applyStimulus(0, 1, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("clr_cnt_a", cnt_a, 8'd5);
        checkOutput("clr_tc_a", {7'd0, tc_a}, 8'd0);

        // Wrap up in [10,20]: 18 + 4 -> 11.
        applyStimulus(0, 0, 1, 8'd18, 0, 1, 8'd0);
        checkOutput("load18_cnt_b", cnt_b, 8'd18);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd4);
        checkOutput("wrapup_cnt_b", cnt_b, 8'd11);
        checkOutput("wrapup_tc_b", {7'd0, tc_b}, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("after_wrap_cnt_b", cnt_b, 8'd12);
        checkOutput("after_wrap_tc_b", {7'd0, tc_b}, 8'd0);

        // Wrap down in [10,20]: 12 - 5 -> 18; then clamped load.
        applyStimulus(0, 0, 1, 8'd12, 0, 1, 8'd0);
        checkOutput("load12_cnt_b", cnt_b, 8'd12);
        applyStimulus(0, 0, 0, 8'd0, 1, 0, 8'd5);
        checkOutput("wrapdn_cnt_b", cnt_b, 8'd18);
        checkOutput("wrapdn_tc_b", {7'd0, tc_b}, 8'd1);
        checkOutput("wrapdn_cnt_a", cnt_a, 8'd7);
        applyStimulus(0, 0, 1, 8'd30, 0, 1, 8'd0);
        checkOutput("clamp_cnt_b", cnt_b, 8'd20);
        checkOutput("clamp_at_max_b", {7'd0, at_max_b}, 8'd1);
        checkOutput("clamp_tc_b", {7'd0, tc_b}, 8'd0);
        applyStimulus(0, 0, 1, 8'd3, 0, 1, 8'd0);
        checkOutput("clamp_lo_cnt_b", cnt_b, 8'd10);

        // Saturate at 255 versus wrap on the full window.
        applyStimulus(0, 0, 1, 8'd250, 0, 1, 8'd0);
        checkOutput("load250_cnt_c", cnt_c, 8'd250);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd10);
        checkOutput("sat_cnt_c", cnt_c, 8'd255);
        checkOutput("sat_tc_c", {7'd0, tc_c}, 8'd1);
        checkOutput("sat_at_max_c", {7'd0, at_max_c}, 8'd1);
        checkOutput("wrapfull_cnt_a", cnt_a, 8'd4);
        checkOutput("wrapfull_tc_a", {7'd0, tc_a}, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd10);
        checkOutput("sat2_cnt_c", cnt_c, 8'd255);
        checkOutput("sat2_tc_c", {7'd0, tc_c}, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 0, 8'd1);
        checkOutput("satdn_cnt_c", cnt_c, 8'd254);
        checkOutput("satdn_tc_c", {7'd0, tc_c}, 8'd0);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd0);
        checkOutput("step0_cnt_c", cnt_c, 8'd254);
        checkOutput("step0_tc_c", {7'd0, tc_c}, 8'd0);

        // Prescale by 3: clear to restart the phase, then count up.
        applyStimulus(0, 1, 0, 8'd0, 0, 1, 8'd0);
        checkOutput("pre_clr_cnt_d", cnt_d, 8'd0);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c1", cnt_d, 8'd0);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c2", cnt_d, 8'd0);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c3", cnt_d, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c5", cnt_d, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c6", cnt_d, 8'd2);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c8", cnt_d, 8'd2);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_c9", cnt_d, 8'd3);
        // One enabled cycle (phase 1), two idle cycles, then two more.
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 8'd1);
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 8'd1);
        checkOutput("pre_hold", cnt_d, 8'd3);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_resume1", cnt_d, 8'd3);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("pre_resume2", cnt_d, 8'd4);
        checkOutput("pre_tc_d", {7'd0, tc_d}, 8'd0);

        // Priority: clr beats load and tick; load beats tick.
        applyStimulus(0, 1, 1, 8'd7, 1, 1, 8'd1);
        checkOutput("prio_clr_cnt_a", cnt_a, 8'd5);
        applyStimulus(0, 0, 1, 8'd7, 1, 1, 8'd1);
        checkOutput("prio_load_cnt_a", cnt_a, 8'd7);
        applyStimulus(0, 0, 0, 8'd0, 1, 1, 8'd1);
        checkOutput("prio_tick_cnt_a", cnt_a, 8'd8);
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
